// File: rtl/mpu_matrix_loader.sv
// Operand loader for the 5x5 matrix multiplier: assembles A then B from a
// row-major byte stream and holds the registered pair until the consumer acks.
module mpu_matrix_loader #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [2:0]                size,
    input  logic [ELEM_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ELEM_W*DIM*DIM-1:0] matrix_a,
    output logic [ELEM_W*DIM*DIM-1:0] matrix_b,
    output logic                      mats_valid,
    input  logic                      mats_ack,
    output logic                      busy,
    output logic                      err
);

    localparam int LANES  = DIM * DIM;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic [2:0]        size_q, size_d;
    logic [ELEM_W-1:0] a_q [LANES];
    logic [ELEM_W-1:0] a_d [LANES];
    logic [ELEM_W-1:0] b_q [LANES];
    logic [ELEM_W-1:0] b_d [LANES];
    logic              in_ready_q, in_ready_d;
    logic              mats_valid_q, mats_valid_d;
    logic              err_q, err_d;

    logic              hs;
    logic              last_col;
    logic              last_row;
    logic [2:0]        size_m1;
    logic [LANE_W-1:0] lane;

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        size_d   = size_q;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = 1'b0;

        hs       = in_valid && in_ready_q;
        size_m1  = size_q - 3'd1;
        last_col = (col_q == size_m1);
        last_row = (row_q == size_m1);
        // Column-major lane packing: element (row, col) sits in lane col*DIM + row.
        lane     = LANE_W'(col_q) * LANE_W'(DIM) + LANE_W'(row_q);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (size != 3'd0 && size <= 3'(DIM)) begin
                        size_d  = size;
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                        state_d = S_LOAD_A;
                        for (int k = 0; k < LANES; k++) begin
                            a_d[k] = '0;
                            b_d[k] = '0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (hs) begin
                    if (state_q == S_LOAD_A) a_d[lane] = in_data;
                    else                     b_d[lane] = in_data;
                    if (last_col) begin
                        col_d = 3'd0;
                        if (last_row) begin
                            row_d   = 3'd0;
                            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_HOLD;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            S_HOLD: begin
                if (mats_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake and valid flags are registered from the next state.
        in_ready_d   = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
        mats_valid_d = (state_d == S_HOLD);
    end

    // NOTE: the element registers are reset too, since the matrix outputs must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            size_q       <= 3'd0;
            in_ready_q   <= 1'b0;
            mats_valid_q <= 1'b0;
            err_q        <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            size_q       <= size_d;
            in_ready_q   <= in_ready_d;
            mats_valid_q <= mats_valid_d;
            err_q        <= err_d;
            a_q          <= a_d;
            b_q          <= b_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_pack
        assign matrix_a[k*ELEM_W +: ELEM_W] = a_q[k];
        assign matrix_b[k*ELEM_W +: ELEM_W] = b_q[k];
    end

    assign in_ready   = in_ready_q;
    assign mats_valid = mats_valid_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Scoreboard bench for mpu_matrix_loader: stimulus pushes expected A/B pairs,
// a monitor pops and compares whenever mats_valid rises and watches HOLD stability.
module tb_mpu_matrix_loader;

    localparam int DIM = 5;
    localparam int EW  = 8;
    localparam int W   = EW * DIM * DIM;

    typedef logic [7:0] byte_q_t[$];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   size = 3'd0;
    logic [EW-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] matrix_a, matrix_b;
    logic         mats_valid;
    logic         mats_ack = 1'b0;
    logic         busy;
    logic         err;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    logic [W-1:0] hold_a, hold_b;
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;
    bit           mv_prev = 1'b0;

    mpu_matrix_loader #(.DIM(DIM), .ELEM_W(EW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .size       (size),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .matrix_a   (matrix_a),
        .matrix_b   (matrix_b),
        .mats_valid (mats_valid),
        .mats_ack   (mats_ack),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference packing: element (r,c) of a row-major stream lands in lane c*DIM+r.
    function automatic logic [W-1:0] pack(input byte_q_t d, input int off, input int sz);
        logic [W-1:0] m;
        m = '0;
        for (int r = 0; r < sz; r++)
            for (int c = 0; c < sz; c++)
                m[(c*DIM + r)*EW +: EW] = d[off + r*sz + c];
        return m;
    endfunction

    // Monitor: compare on each rising mats_valid, then demand stability while it stays high.
    always @(negedge clk) begin
        if (!rst_n) begin
            mv_prev = 1'b0;
        end else begin
            if (mats_valid && !mv_prev) begin
                if (exp_a_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_mats_valid: got 1 expected 0");
                end else begin
                    hold_a = exp_a_q.pop_front();
                    hold_b = exp_b_q.pop_front();
                    check("matrix_a", matrix_a, hold_a);
                    check("matrix_b", matrix_b, hold_b);
                end
            end else if (mats_valid && mv_prev) begin
                check("hold_a_stable", matrix_a, hold_a);
                check("hold_b_stable", matrix_b, hold_b);
            end
            mv_prev = mats_valid;
        end
    end

    task automatic start_load(input int sz);
        @(negedge clk);
        start = 1'b1;
        size  = 3'(sz);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", W'(busy), W'(1));
        check("in_ready_after_start", W'(in_ready), W'(1));
        check("err_after_start", W'(err), W'(0));
    endtask

    // Drives elements with a gap pattern; returns at the negedge right after the last handshake.
    task automatic stream(input byte_q_t d, input int mode, input int stop_after, output int hs);
        int idx;
        int cyc;
        bit pv;
        bit pr;
        hs = 0; idx = 0; cyc = 0; pv = 1'b0; pr = 1'b0;
        forever begin
            @(negedge clk);
            if (pv && pr) begin
                hs++;
                idx++;
            end
            if (hs >= stop_after) break;
            if (cyc > 8*stop_after + 20) begin
                n_vec++;
                n_bad++;
                $display("FAIL stream_timeout: got %0d handshakes expected %0d", hs, stop_after);
                break;
            end
            cyc++;
            case (mode)
                0:       pv = 1'b1;
                1:       pv = (cyc % 2 == 1);
                default: pv = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = pv;
            in_data  = pv ? d[idx] : 8'($urandom);
            pr       = in_ready;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_load(input int sz, input int mode, input byte_q_t d);
        int hs;
        logic [W-1:0] ea, eb;
        ea = pack(d, 0, sz);
        eb = pack(d, sz*sz, sz);
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        start_load(sz);
        stream(d, mode, 2*sz*sz, hs);
        check("mats_valid_after_last", W'(mats_valid), W'(1));
        check("in_ready_in_hold", W'(in_ready), W'(0));
        last_a = ea;
        last_b = eb;
    endtask

    task automatic ack(input int delay);
        repeat (delay) @(negedge clk);
        mats_ack = 1'b1;
        @(negedge clk);
        mats_ack = 1'b0;
        check("mats_valid_after_ack", W'(mats_valid), W'(0));
        check("busy_after_ack", W'(busy), W'(0));
        check("idle_keeps_a", matrix_a, last_a);
        check("idle_keeps_b", matrix_b, last_b);
    endtask

    function automatic byte_q_t rand_data(input int sz);
        byte_q_t d;
        for (int k = 0; k < 2*sz*sz; k++) d.push_back(8'($urandom));
        return d;
    endfunction

    initial begin
        byte_q_t d;
        int hs;

        // Reset state
        #1;
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_mats_valid", W'(mats_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_err", W'(err), W'(0));
        check("rst_matrix_a", matrix_a, '0);
        check("rst_matrix_b", matrix_b, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full 5x5: A = 1..25 row-major, B = identity
        d = {};
        for (int k = 1; k <= 25; k++) d.push_back(8'(k));
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) d.push_back((r == c) ? 8'd1 : 8'd0);
        run_load(5, 0, d);
        check("a_r0c1", W'(matrix_a[47:40]), W'(2));
        check("b_r4c4", W'(matrix_b[199:192]), W'(1));
        repeat (10) @(negedge clk);
        check("hold_10_valid", W'(mats_valid), W'(1));
        ack(0);

        // 3x3 with toggling in_valid, then extra valid beats in HOLD must be ignored
        d = rand_data(3);
        run_load(3, 1, d);
        check("a_r2c2_lane12", W'(matrix_a[12*EW +: EW]), W'(d[8]));
        in_valid = 1'b1;
        in_data  = 8'hff;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        ack(1);

        // Illegal sizes in IDLE
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start = 1'b1;
            size  = (t == 0) ? 3'd0 : 3'd6;
            @(negedge clk);
            start = 1'b0;
            check("err_pulse", W'(err), W'(1));
            check("err_busy", W'(busy), W'(0));
            check("err_in_ready", W'(in_ready), W'(0));
            @(negedge clk);
            check("err_one_cycle", W'(err), W'(0));
            check("err_keeps_a", matrix_a, last_a);
            check("err_keeps_b", matrix_b, last_b);
        end

        // Asynchronous reset after 7 B handshakes, then a clean 2x2 load
        d = rand_data(4);
        start_load(4);
        stream(d, 0, 16 + 7, hs);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_matrix_a", matrix_a, '0);
        check("midrst_matrix_b", matrix_b, '0);
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(0));
        check("midrst_mats_valid", W'(mats_valid), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        d = rand_data(2);
        run_load(2, 2, d);

        // start ignored in HOLD, and alongside mats_ack
        @(negedge clk);
        start = 1'b1;
        size  = 3'd3;
        @(negedge clk);
        start = 1'b0;
        check("hold_start_valid", W'(mats_valid), W'(1));
        check("hold_start_busy", W'(busy), W'(1));
        check("hold_start_err", W'(err), W'(0));
        start    = 1'b1;
        size     = 3'd2;
        mats_ack = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        mats_ack = 1'b0;
        check("ackstart_valid", W'(mats_valid), W'(0));
        check("ackstart_busy", W'(busy), W'(0));
        check("ackstart_in_ready", W'(in_ready), W'(0));
        @(negedge clk);
        check("ackstart_no_load", W'(busy), W'(0));
        check("ackstart_keeps_a", matrix_a, last_a);

        // Randomized loads
        for (int t = 0; t < 6; t++) begin
            int sz;
            sz = $urandom_range(1, DIM);
            d  = rand_data(sz);
            run_load(sz, 2, d);
            ack($urandom_range(0, 4));
        end

        repeat (2) @(negedge clk);
        if (exp_a_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_a_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
